cpu_run_ctrl: RTL and testbench

//   Run/dump sequencer for the single-cycle CPU.
//   - Drives the CPU's start_i input and counts executed cycles.
//   - Stops the CPU on a cycle limit or on a halt indication.
//   - Then streams a snapshot (PC, then R0..R31) over a valid/ready port, read

---
 rtl/cpu_run_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// ----------------------------------------------------------------------------
// cpu_run_ctrl
//
// Run/dump sequencer for the single-cycle CPU.
//   1. On a go request it raises cpu_start_o and counts executed cycles.
//   2. It stops the CPU when the cycle limit is reached or halt_i is seen.
//   3. It then streams a snapshot over a valid/ready port:
//      the PC first, then R0..R31 read through the register file's
//      combinational debug read port.
// This gives the bench a synthesizable view of architectural state, so it
// does not need hierarchical peeking into the register file.
//
// Optional feature (compile-time macro DUMP_CYCLES_EN):
//   defined   : one extra final beat, tag 33, carrying the cycle count
//               (34 beats in total).
//   undefined : the dump ends after tag 32 (33 beats).
//
// Parameters:
//   MAX_CYCLES  run length used when cycle_limit_i == 0
//   CNT_W       width of the cycle counter and of cycle_limit_i
//
// Ports:
//   clk_i          in   clock, all state on posedge
//   rst_i          in   asynchronous active-high reset
//   go_i           in   start request, sampled in IDLE/DONE only
//   cycle_limit_i  in   run length in cycles; 0 selects MAX_CYCLES
//   halt_i         in   CPU halt indication, sampled in RUN
//   pc_i           in   CPU program counter
//   cpu_start_o    out  CPU run enable, high only in RUN
//   dbg_addr_o     out  register-file debug read address
//   dbg_data_i     in   register-file debug read data (combinational)
//   dump_valid_o   out  dump beat valid
//   dump_ready_i   in   dump beat accepted when valid && ready
//   dump_tag_o     out  0=PC, 1..32=R0..R31, 33=cycle count (option)
//   dump_data_o    out  beat payload (combinational from tag)
//   busy_o         out  high in RUN or DUMP
//   done_o         out  high in DONE
//   cycles_o       out  cycles executed in the current/last run
// ----------------------------------------------------------------------------
module cpu_run_ctrl #(
    parameter int MAX_CYCLES = 30,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             go_i,
    input  logic [CNT_W-1:0] cycle_limit_i,
    input  logic             halt_i,
    input  logic [31:0]      pc_i,
    output logic             cpu_start_o,
    output logic [4:0]       dbg_addr_o,
    input  logic [31:0]      dbg_data_i,
    output logic             dump_valid_o,
    input  logic             dump_ready_i,
    output logic [5:0]       dump_tag_o,
    output logic [31:0]      dump_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] cycles_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DUMP,
        S_DONE
    } state_t;

`ifdef DUMP_CYCLES_EN
    localparam logic [5:0] LAST_TAG = 6'd33;
`else
    localparam logic [5:0] LAST_TAG = 6'd32;
`endif

    localparam logic [CNT_W-1:0] DEFAULT_LIMIT = CNT_W'(MAX_CYCLES);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t           state_q,    state_d;
    logic [CNT_W-1:0] cycles_q,   cycles_d;
    logic [CNT_W-1:0] limit_q,    limit_d;
    logic             start_q,    start_d;
    logic [31:0]      pc_latch_q, pc_latch_d;
    logic [5:0]       tag_q,      tag_d;
    logic             valid_q,    valid_d;
    logic [4:0]       dbg_addr_q, dbg_addr_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;

    logic [CNT_W-1:0] cycles_inc;

    // The limit is at most 2^CNT_W-1, so this never wraps while in RUN.
    assign cycles_inc = cycles_q + CNT_W'(1);

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so that no
        // path leaves it unassigned; otherwise a latch would be inferred.
        state_d    = state_q;
        cycles_d   = cycles_q;
        limit_d    = limit_q;
        start_d    = start_q;
        pc_latch_d = pc_latch_q;
        tag_d      = tag_q;
        valid_d    = valid_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (go_i) begin
                    state_d  = S_RUN;
                    cycles_d = '0;
                    start_d  = 1'b1;
                    tag_d    = '0;
                    limit_d  = (cycle_limit_i == '0) ? DEFAULT_LIMIT
                                                     : cycle_limit_i;
                end
            end

            S_RUN: begin
                cycles_d = cycles_inc;
                // Limit and halt on the same edge take the same single exit.
                if ((cycles_inc == limit_q) || halt_i) begin
                    state_d    = S_DUMP;
                    start_d    = 1'b0;
                    pc_latch_d = pc_i;
                    tag_d      = '0;
                    valid_d    = 1'b1;
                end
            end

            S_DUMP: begin
                if (valid_q && dump_ready_i) begin
                    if (tag_q == LAST_TAG) begin
                        valid_d = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        tag_d = tag_q + 6'd1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_DUMP);
        done_d = (state_d == S_DONE);

        // The debug address is registered, so it is derived from the tag of
        // the next cycle. That way the register file presents R[tag-1]
        // together with the tag it belongs to.
        if ((state_d == S_DUMP) && (tag_d >= 6'd1) && (tag_d <= 6'd32)) begin
            dbg_addr_d = 5'(tag_d - 6'd1);
        end else begin
            dbg_addr_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cycles_q   <= '0;
            limit_q    <= '0;
            start_q    <= 1'b0;
            pc_latch_q <= '0;
            tag_q      <= '0;
            valid_q    <= 1'b0;
            dbg_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make all registers update
            // together from the values present before the edge.
            state_q    <= state_d;
            cycles_q   <= cycles_d;
            limit_q    <= limit_d;
            start_q    <= start_d;
            pc_latch_q <= pc_latch_d;
            tag_q      <= tag_d;
            valid_q    <= valid_d;
            dbg_addr_q <= dbg_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Beat payload: the only combinational output. It follows the current
    // tag. The register-file data is stable because the CPU is stopped.
    // ------------------------------------------------------------------
    always_comb begin
        dump_data_o = '0;
        if (tag_q == 6'd0) begin
            dump_data_o = pc_latch_q;
        end else if (tag_q <= 6'd32) begin
            dump_data_o = dbg_data_i;
        end
`ifdef DUMP_CYCLES_EN
        else if (tag_q == 6'd33) begin
            dump_data_o = 32'(cycles_q);
        end
`endif
    end

    assign cpu_start_o  = start_q;
    assign dbg_addr_o   = dbg_addr_q;
    assign dump_valid_o = valid_q;
    assign dump_tag_o   = tag_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign cycles_o     = cycles_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cpu_run_ctrl
//
// Scoreboard bench for cpu_run_ctrl. When a run ends, the expected dump beats
// are built from the bench's own register-file model and from the PC value it
// drove. They are popped and compared on every valid/ready handshake.
// ----------------------------------------------------------------------------
module tb_cpu_run_ctrl;

    localparam int CNT_W = 16;
`ifdef DUMP_CYCLES_EN
    localparam int NBEATS = 34;
`else
    localparam int NBEATS = 33;
`endif

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             go_i;
    logic [CNT_W-1:0] cycle_limit_i;
    logic             halt_i;
    logic [31:0]      pc_i;
    logic             cpu_start_o;
    logic [4:0]       dbg_addr_o;
    logic [31:0]      dbg_data_i;
    logic             dump_valid_o;
    logic             dump_ready_i;
    logic [5:0]       dump_tag_o;
    logic [31:0]      dump_data_o;
    logic             busy_o;
    logic             done_o;
    logic [CNT_W-1:0] cycles_o;

    typedef struct packed {
        logic [5:0]  tag;
        logic [31:0] data;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] regs [0:31];
    int          checks   = 0;
    int          failures = 0;

    always #5 clk_i = ~clk_i;

    // Register-file model with a combinational debug read port.
    assign dbg_data_i = regs[dbg_addr_o];

    cpu_run_ctrl #(.MAX_CYCLES(30), .CNT_W(CNT_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .go_i         (go_i),
        .cycle_limit_i(cycle_limit_i),
        .halt_i       (halt_i),
        .pc_i         (pc_i),
        .cpu_start_o  (cpu_start_o),
        .dbg_addr_o   (dbg_addr_o),
        .dbg_data_i   (dbg_data_i),
        .dump_valid_o (dump_valid_o),
        .dump_ready_i (dump_ready_i),
        .dump_tag_o   (dump_tag_o),
        .dump_data_o  (dump_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .cycles_o     (cycles_o)
    );

    // ------------------------------------------------------------------
    // Start a run at a negedge in IDLE/DONE and follow it until the CPU is
    // stopped. Afterwards, push the expected dump beats.
    // ------------------------------------------------------------------
    task automatic run_phase(input int limit, input int halt_at, input bit hold_go);
        int eff;
        int exp_cyc;
        int n;
        eff     = (limit == 0) ? 30 : limit;
        exp_cyc = (halt_at > 0 && halt_at < eff) ? halt_at : eff;
        go_i          = 1'b1;
        cycle_limit_i = CNT_W'(limit);
        pc_i          = $urandom;
        @(negedge clk_i);
        if (!hold_go) go_i = 1'b0;
        n = 0;
        while (cpu_start_o && n < 1000) begin
            n++;
            checks++;
            if (cycles_o !== CNT_W'(n - 1)) begin
                failures++;
                $display("FAIL run_count: cycles_o=%0d expected %0d", cycles_o, n - 1);
            end
            pc_i   = $urandom;
            halt_i = (n == halt_at);
            @(negedge clk_i);
        end
        halt_i = 1'b0;
        checks++;
        if (n != exp_cyc) begin
            failures++;
            $display("FAIL start_len: cpu_start_o high %0d cycles, expected %0d", n, exp_cyc);
        end
        checks++;
        if (cycles_o !== CNT_W'(exp_cyc)) begin
            failures++;
            $display("FAIL run_cycles: cycles_o=%0d expected %0d", cycles_o, exp_cyc);
        end
        checks++;
        if ({busy_o, dump_valid_o, done_o} !== 3'b110) begin
            failures++;
            $display("FAIL dump_entry: busy/valid/done=%b expected 110", {busy_o, dump_valid_o, done_o});
        end
        exp_q.push_back('{tag: 6'd0, data: pc_i});
        for (int t = 1; t <= 32; t++) exp_q.push_back('{tag: 6'(t), data: regs[t-1]});
`ifdef DUMP_CYCLES_EN
        exp_q.push_back('{tag: 6'd33, data: 32'(exp_cyc)});
`endif
    endtask

    // ------------------------------------------------------------------
    // Consume dump beats.
    //   mode 0: ready held high.
    //   mode 1: ready follows the pattern 1,0,0,1.
    // abort_tag >= 0 stops at that tag before it is accepted.
    // ------------------------------------------------------------------
    task automatic dump_phase(input int mode, input int abort_tag, input bit check_consec,
                              output bit aborted);
        int          i;
        int          beats;
        int          first_i;
        int          last_i;
        bit          stalled;
        logic [5:0]  st_tag;
        logic [31:0] st_data;
        beat_t       e;
        i = 0; beats = 0; first_i = -1; last_i = -1; stalled = 0; aborted = 0;
        st_tag = '0; st_data = '0;
        while (!done_o && i < 400 && !aborted) begin
            if (abort_tag >= 0 && dump_valid_o && dump_tag_o == 6'(abort_tag)) begin
                aborted = 1;
            end else begin
                if (stalled) begin
                    checks++;
                    if ({dump_valid_o, dump_tag_o, dump_data_o} !== {1'b1, st_tag, st_data}) begin
                        failures++;
                        $display("FAIL stall_hold: tag=%0d data=%h expected tag=%0d data=%h",
                                 dump_tag_o, dump_data_o, st_tag, st_data);
                    end
                end
                dump_ready_i = (mode == 1) ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
                if (dump_valid_o && dump_ready_i) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL extra_beat: tag=%0d data=%h expected no beat", dump_tag_o, dump_data_o);
                    end else begin
                        e = exp_q.pop_front();
                        if ({dump_tag_o, dump_data_o} !== {e.tag, e.data}) begin
                            failures++;
                            $display("FAIL beat: tag=%0d data=%h expected tag=%0d data=%h",
                                     dump_tag_o, dump_data_o, e.tag, e.data);
                        end
                        if (mode == 1 && e.tag == 6'd6) begin
                            checks++;
                            if (dump_data_o !== 32'h0000_00AB) begin
                                failures++;
                                $display("FAIL r5_beat: data=%h expected 000000ab", dump_data_o);
                            end
                        end
                    end
                    beats++;
                    if (first_i < 0) first_i = i;
                    last_i = i;
                end
                stalled = dump_valid_o && !dump_ready_i;
                st_tag  = dump_tag_o;
                st_data = dump_data_o;
                i++;
                @(negedge clk_i);
            end
        end
        if (!aborted) begin
            checks++;
            if (done_o !== 1'b1) begin
                failures++;
                $display("FAIL dump_done: done_o=%b expected 1 (budget expired)", done_o);
            end
            checks++;
            if (beats != NBEATS || exp_q.size() != 0) begin
                failures++;
                $display("FAIL beat_count: beats=%0d left=%0d expected %0d and 0", beats, exp_q.size(), NBEATS);
            end
            checks++;
            if ({busy_o, dump_valid_o, cpu_start_o} !== 3'b000) begin
                failures++;
                $display("FAIL done_outputs: busy/valid/start=%b expected 000",
                         {busy_o, dump_valid_o, cpu_start_o});
            end
            if (check_consec) begin
                checks++;
                if (last_i - first_i + 1 != NBEATS) begin
                    failures++;
                    $display("FAIL back_to_back: beats spanned %0d cycles expected %0d",
                             last_i - first_i + 1, NBEATS);
                end
            end
        end
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({cpu_start_o, dump_valid_o, dump_tag_o, busy_o, done_o, cycles_o, dbg_addr_o, dump_data_o} !== '0) begin
            failures++;
            $display("FAIL %s: start=%b valid=%b tag=%0d busy=%b done=%b cycles=%0d addr=%0d data=%h expected all 0",
                     name, cpu_start_o, dump_valid_o, dump_tag_o, busy_o, done_o, cycles_o, dbg_addr_o, dump_data_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; go_i = 1'b0; halt_i = 1'b0; dump_ready_i = 1'b0;
        cycle_limit_i = '0; pc_i = '0;
        repeat (2) @(negedge clk_i);
        check_all_zero("reset_state");
        rst_i = 1'b0;
        @(negedge clk_i);
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_default_limit();
        bit ab;
        dump_ready_i = 1'b1;
        run_phase(0, 0, 0);
        dump_phase(0, -1, 1, ab);
        checks++;
        if (cycles_o !== CNT_W'(30)) begin
            failures++;
            $display("FAIL cycles_hold: cycles_o=%0d expected 30", cycles_o);
        end
    endtask

    task automatic test_halt();
        bit ab;
        run_phase(5, 3, 0);
        dump_phase(0, -1, 0, ab);
    endtask

    task automatic test_stall();
        bit ab;
        run_phase(4, 0, 0);
        dump_phase(1, -1, 0, ab);
    endtask

    task automatic test_reset_mid_dump();
        bit ab;
        run_phase(8, 0, 0);
        dump_phase(0, 10, 0, ab);
        checks++;
        if (ab !== 1'b1) begin
            failures++;
            $display("FAIL reach_tag10: aborted=%b expected 1", ab);
        end
        rst_i = 1'b1;
        #1;
        check_all_zero("reset_mid_dump");
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        run_phase(4, 0, 0);
        dump_phase(0, -1, 0, ab);
    endtask

    task automatic test_go_held();
        bit ab;
        run_phase(6, 0, 1);
        dump_phase(0, -1, 0, ab);
        // go_i is still high here, so the next edge restarts from DONE.
        run_phase(6, 0, 0);
        dump_phase(0, -1, 0, ab);
    endtask

    task automatic test_cycles_beat();
        bit ab;
        run_phase(7, 0, 0);
        dump_phase(0, -1, 1, ab);
    endtask

    task automatic test_halt_at_limit();
        bit ab;
        run_phase(4, 4, 0);
        dump_phase(1, -1, 0, ab);
    endtask

    initial begin
        for (int r = 0; r < 32; r++) regs[r] = 32'hC0DE_0000 + 32'(r) * 32'h0000_0101;
        regs[0] = 32'h0;
        regs[5] = 32'h0000_00AB;
        test_reset();
        test_default_limit();
        test_halt();
        test_stall();
        test_reset_mid_dump();
        test_go_held();
        test_cycles_beat();
        test_halt_at_limit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
